softbit_packer: RTL and testbench

- Upstream feeder for viterbi_core; fills the 24-bit source softbit buffer (sram_24x4096 port) for one frame.
- Accepts a stream of 8-bit signed demapper LLRs and saturates each to a 4-bit symmetric softbit.
- Packs num_poly_i softbits (one per generator polynomial) into one 24-bit word and writes it at consecutive addresses.
- Pulses fill_done_o after the last write; this pulse drives viterbi_core frame_start_i directly.

---
 rtl/softbit_packer.sv | 183 ++++++++++++++++++
 tb/tb_softbit_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/softbit_packer.sv
// softbit_packer: saturates a stream of signed demapper LLRs to 4-bit symmetric
// softbits and packs num_poly of them per 24-bit word into the viterbi source
// buffer at consecutive addresses. Pulses fill_done_o after the final write.
// Ports:
//   clk_i, rst_an_i (async, active low), rst_sync_i (sync clear, active high)
//   cfg_start_i, num_poly_i, word_count_i, dst_start_addr_i : frame config
//   sb_valid_i, sb_data_i, sb_ready_o                          : LLR stream
//   sram_wr_o, sram_addr_o, sram_wdata_o                       : buffer write
//   busy_o, fill_done_o                                        : frame status
module softbit_packer #(
  parameter int unsigned SB_IN_W   = 8,
  parameter int unsigned SB_W      = 4,
  parameter int unsigned NPOLY_MAX = 6,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LEN_W     = 13
) (
  input  logic                      clk_i,
  input  logic                      rst_an_i,
  input  logic                      rst_sync_i,
  input  logic                      cfg_start_i,
  input  logic [2:0]                num_poly_i,
  input  logic [LEN_W-1:0]          word_count_i,
  input  logic [ADDR_W-1:0]         dst_start_addr_i,
  input  logic                      sb_valid_i,
  input  logic [SB_IN_W-1:0]        sb_data_i,
  output logic                      sb_ready_o,
  output logic                      sram_wr_o,
  output logic [ADDR_W-1:0]         sram_addr_o,
  output logic [SB_W*NPOLY_MAX-1:0] sram_wdata_o,
  output logic                      busy_o,
  output logic                      fill_done_o
);

  localparam int unsigned WORD_W  = SB_W * NPOLY_MAX;
  localparam int unsigned NP_W    = 3;
  localparam int          SAT_MAX = (2 ** (SB_W - 1)) - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [NP_W-1:0]     npoly_q, npoly_d;
  logic [NP_W-1:0]     slot_q, slot_d;
  logic [LEN_W-1:0]    wcount_q, wcount_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                ready_d, wr_d, busy_d, done_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [WORD_W-1:0]   wdata_d;
  logic [WORD_W-1:0]   merged;
  logic [SB_W-1:0]     sb_sat;
  logic                accept;

  // Symmetric saturation: the most negative code is never produced.
  function automatic logic [SB_W-1:0] sat_llr(input logic [SB_IN_W-1:0] llr);
    int v;
    v = int'($signed(llr));
    if (v > SAT_MAX)       sat_llr = SB_W'(SAT_MAX);
    else if (v < -SAT_MAX) sat_llr = SB_W'(-SAT_MAX);
    else                   sat_llr = llr[SB_W-1:0];
  endfunction

  // Out-of-range polynomial counts fold into the supported 2..NPOLY_MAX range.
  function automatic logic [NP_W-1:0] clamp_np(input logic [NP_W-1:0] np);
    if (np < NP_W'(2))                   clamp_np = NP_W'(2);
    else if (np > NP_W'(NPOLY_MAX))      clamp_np = NP_W'(NPOLY_MAX);
    else                                 clamp_np = np;
  endfunction

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d  = state_q;
    npoly_d  = npoly_q;
    slot_d   = slot_q;
    wcount_d = wcount_q;
    words_d  = words_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    wr_d     = 1'b0;
    waddr_d  = sram_addr_o;
    wdata_d  = sram_wdata_o;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    accept = sb_valid_i && sb_ready_o;
    sb_sat = sat_llr(sb_data_i);
    merged = buf_q;
    for (int k = 0; k < int'(NPOLY_MAX); k++) begin
      if (slot_q == NP_W'(k)) merged[k*SB_W +: SB_W] = sb_sat;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          npoly_d  = clamp_np(num_poly_i);
          wcount_d = word_count_i;
          words_d  = '0;
          slot_d   = '0;
          buf_d    = '0;
          addr_d   = dst_start_addr_i;
          state_d  = (word_count_i == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        // Final word is on the bus this cycle once the count is reached.
        if (words_q == wcount_q) begin
          state_d = ST_DONE;
        end else if (accept) begin
          if (slot_q == NP_W'(npoly_q - NP_W'(1))) begin
            wr_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = merged;
            addr_d  = addr_q + ADDR_W'(1);
            words_d = words_q + LEN_W'(1);
            slot_d  = '0;
            buf_d   = '0;
          end else begin
            slot_d = slot_q + NP_W'(1);
            buf_d  = merged;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_FILL) && (words_d < wcount_d);
    busy_d  = (state_d == ST_FILL);
    done_d  = (state_d == ST_DONE);

    // Synchronous clear overrides everything, including an in-flight write.
    if (rst_sync_i) begin
      state_d  = ST_IDLE;
      npoly_d  = '0;
      slot_d   = '0;
      wcount_d = '0;
      words_d  = '0;
      addr_d   = '0;
      buf_d    = '0;
      wr_d     = 1'b0;
      waddr_d  = '0;
      wdata_d  = '0;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q      <= ST_IDLE;
      npoly_q      <= '0;
      slot_q       <= '0;
      wcount_q     <= '0;
      words_q      <= '0;
      addr_q       <= '0;
      buf_q        <= '0;
      sb_ready_o   <= 1'b0;
      sram_wr_o    <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      busy_o       <= 1'b0;
      fill_done_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      npoly_q      <= npoly_d;
      slot_q       <= slot_d;
      wcount_q     <= wcount_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      sb_ready_o   <= ready_d;
      sram_wr_o    <= wr_d;
      sram_addr_o  <= waddr_d;
      sram_wdata_o <= wdata_d;
      busy_o       <= busy_d;
      fill_done_o  <= done_d;
    end
  end

endmodule

// File: tb/tb_softbit_packer.sv
// Self-checking bench for softbit_packer: directed table vectors, reset
// sequences and randomized frames against a behavioural packing model.
module tb_softbit_packer;

  logic        clk_i = 1'b0;
  logic        rst_an_i, rst_sync_i, cfg_start_i;
  logic [2:0]  num_poly_i;
  logic [12:0] word_count_i;
  logic [11:0] dst_start_addr_i;
  logic        sb_valid_i;
  logic [7:0]  sb_data_i;
  logic        sb_ready_o, sram_wr_o, busy_o, fill_done_o;
  logic [11:0] sram_addr_o;
  logic [23:0] sram_wdata_o;

  always #5 clk_i = ~clk_i;

  softbit_packer dut (
    .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i),
    .cfg_start_i(cfg_start_i), .num_poly_i(num_poly_i),
    .word_count_i(word_count_i), .dst_start_addr_i(dst_start_addr_i),
    .sb_valid_i(sb_valid_i), .sb_data_i(sb_data_i), .sb_ready_o(sb_ready_o),
    .sram_wr_o(sram_wr_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .busy_o(busy_o), .fill_done_o(fill_done_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [11:0] got_a[$];
  logic [23:0] got_d[$];
  int          done_cnt, done_cyc, wr_cyc;
  logic        busy_seen, ready_at_wr;

  always @(negedge clk_i) begin
    if (sram_wr_o) begin
      got_a.push_back(sram_addr_o);
      got_d.push_back(sram_wdata_o);
      wr_cyc = cyc;
      ready_at_wr = sb_ready_o;
    end
    if (fill_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_seen = 1'b1;
  end

  // Reference model: symmetric saturation and nibble packing by arithmetic.
  logic [7:0]  llr_q[$];
  logic [11:0] exp_a[$];
  logic [23:0] exp_d[$];

  function automatic logic [3:0] ref_sat(input logic [7:0] b);
    int v;
    v = int'($signed(b));
    if (v > 7)  v = 7;
    if (v < -7) v = -7;
    return 4'(v);
  endfunction

  function automatic int ref_np(input int raw);
    if (raw < 2) return 2;
    if (raw > 6) return 6;
    return raw;
  endfunction

  task automatic build_expect(input int np, input int wc, input int sa);
    exp_a.delete();
    exp_d.delete();
    for (int w = 0; w < wc; w++) begin
      int word;
      word = 0;
      for (int k = 0; k < np; k++)
        word += int'(ref_sat(llr_q[w*np + k])) * (16 ** k);
      exp_a.push_back(12'((sa + w) % 4096));
      exp_d.push_back(24'(word));
    end
  endtask

  int last_acc;

  // Drive one LLR, hold it until accepted; optionally poke a stray cfg_start.
  task automatic send_llr(input logic [7:0] d, input int gap, input bit poke, input string tag);
    int bound;
    repeat (gap) @(negedge clk_i);
    sb_valid_i = 1'b1;
    sb_data_i  = d;
    if (poke) begin
      cfg_start_i      = 1'b1;
      num_poly_i       = 3'($urandom);
      word_count_i     = 13'($urandom);
      dst_start_addr_i = 12'($urandom);
    end
    bound = 0;
    while (!sb_ready_o && bound < 100) begin
      @(negedge clk_i);
      cfg_start_i = 1'b0;
      bound++;
    end
    check({tag, " ready_timeout"}, 32'(bound >= 100), 32'd0);
    last_acc = cyc;
    @(negedge clk_i);
    sb_valid_i  = 1'b0;
    cfg_start_i = 1'b0;
  endtask

  task automatic clear_monitor();
    got_a.delete();
    got_d.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    wr_cyc    = -1;
    busy_seen = 1'b0;
  endtask

  task automatic start_cfg(input logic [2:0] np, input logic [12:0] wc, input logic [11:0] sa);
    cfg_start_i      = 1'b1;
    num_poly_i       = np;
    word_count_i     = wc;
    dst_start_addr_i = sa;
    @(negedge clk_i);
    cfg_start_i      = 1'b0;
    num_poly_i       = 3'($urandom);
    word_count_i     = 13'($urandom);
    dst_start_addr_i = 12'($urandom);
  endtask

  // Full frame: configure, stream llr_q, compare against exp_a/exp_d.
  task automatic run_frame(input logic [2:0] np, input logic [12:0] wc, input logic [11:0] sa,
                           input int max_gap, input int poke_idx, input string tag);
    int cfg_cyc, bound;
    clear_monitor();
    cfg_cyc = cyc;
    start_cfg(np, wc, sa);
    if (wc != 0) begin
      check({tag, " ready_at_1"}, 32'(sb_ready_o), 32'd1);
      check({tag, " busy_at_1"}, 32'(busy_o), 32'd1);
    end
    for (int i = 0; i < llr_q.size(); i++)
      send_llr(llr_q[i], $urandom_range(0, max_gap), i == poke_idx, tag);
    bound = 0;
    while (done_cnt == 0 && bound < 50) begin
      @(negedge clk_i);
      bound++;
    end
    repeat (4) @(negedge clk_i);
    check({tag, " writes"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), 32'(got_a[i]), 32'(exp_a[i]));
      check($sformatf("%s data%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
    end
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    if (wc != 0) begin
      check({tag, " wr_latency"}, 32'(wr_cyc), 32'(last_acc + 1));
      check({tag, " done_latency"}, 32'(done_cyc), 32'(last_acc + 2));
      check({tag, " ready_low_at_last_wr"}, 32'(ready_at_wr), 32'd0);
    end else begin
      check({tag, " done_at_1"}, 32'(done_cyc), 32'(cfg_cyc + 1));
      check({tag, " busy_never"}, 32'(busy_seen), 32'd0);
    end
    check({tag, " idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  typedef struct packed {
    logic [2:0]        np;
    logic [12:0]       wc;
    logic [11:0]       sa;
    logic [3:0]        n;
    logic [2:0][11:0]  ea;   // element 0 is the first write
    logic [2:0][23:0]  ed;
  } vec_t;

  vec_t vecs [4];
  int llr_tab [4][9] = '{'{1, -1, 2, -2, 3, -3, 0, 0, 0},
                         '{127, -128, 8, -8, 7, -7, 0, 0, 0},
                         '{0, 1, 2, 3, 4, 5, 6, 7, 8},
                         '{0, 0, 0, 0, 0, 0, 0, 0, 0}};

  initial begin
    vecs[0] = '{np: 3'd2, wc: 13'd3, sa: 12'd0, n: 4'd6,
                ea: {12'd2, 12'd1, 12'd0}, ed: {24'h0000D3, 24'h0000E2, 24'h0000F1}};
    vecs[1] = '{np: 3'd6, wc: 13'd1, sa: 12'd10, n: 4'd6,
                ea: {12'd0, 12'd0, 12'd10}, ed: {24'h0, 24'h0, 24'h979797}};
    vecs[2] = '{np: 3'd3, wc: 13'd3, sa: 12'd4094, n: 4'd9,
                ea: {12'd0, 12'd4095, 12'd4094}, ed: {24'h000776, 24'h000543, 24'h000210}};
    vecs[3] = '{np: 3'd2, wc: 13'd0, sa: 12'd33, n: 4'd0,
                ea: '0, ed: '0};

    rst_an_i = 1'b0; rst_sync_i = 1'b0; cfg_start_i = 1'b0;
    num_poly_i = '0; word_count_i = '0; dst_start_addr_i = '0;
    sb_valid_i = 1'b0; sb_data_i = '0;
    clear_monitor();
    repeat (3) @(negedge clk_i);
    check("reset sb_ready", 32'(sb_ready_o), 32'd0);
    check("reset sram_wr", 32'(sram_wr_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset fill_done", 32'(fill_done_o), 32'd0);
    check("reset addr", 32'(sram_addr_o), 32'd0);
    check("reset wdata", 32'(sram_wdata_o), 32'd0);
    rst_an_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Directed table vectors at full input rate.
    for (int v = 0; v < 4; v++) begin
      llr_q.delete();
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) llr_q.push_back(8'(llr_tab[v][i]));
      for (int i = 0; i < int'(vecs[v].wc); i++) begin
        exp_a.push_back(vecs[v].ea[i]);
        exp_d.push_back(vecs[v].ed[i]);
      end
      run_frame(vecs[v].np, vecs[v].wc, vecs[v].sa, 0, -1, $sformatf("vec%0d", v));
    end

    // Async reset after one of two slots: partial word dropped, no done pulse.
    clear_monitor();
    start_cfg(3'd2, 13'd2, 12'd100);
    send_llr(8'h05, 0, 1'b0, "arst");
    rst_an_i = 1'b0;
    @(negedge clk_i);
    check("arst busy", 32'(busy_o), 32'd0);
    check("arst ready", 32'(sb_ready_o), 32'd0);
    rst_an_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("arst no_write", 32'(got_a.size()), 32'd0);
    check("arst no_done", 32'(done_cnt), 32'd0);
    llr_q = '{8'h03, 8'hFD};
    exp_a = '{12'd200};
    exp_d = '{24'h0000D3};
    run_frame(3'd2, 13'd1, 12'd200, 0, -1, "after_arst");

    // Synchronous clear mid-frame.
    clear_monitor();
    start_cfg(3'd3, 13'd2, 12'd7);
    send_llr(8'h01, 0, 1'b0, "srst");
    send_llr(8'h02, 0, 1'b0, "srst");
    rst_sync_i = 1'b1;
    @(negedge clk_i);
    rst_sync_i = 1'b0;
    check("srst busy", 32'(busy_o), 32'd0);
    check("srst ready", 32'(sb_ready_o), 32'd0);
    repeat (4) @(negedge clk_i);
    check("srst no_write", 32'(got_a.size()), 32'd0);
    check("srst no_done", 32'(done_cnt), 32'd0);

    // Randomized frames with gaps, clamped num_poly and stray cfg_start pokes.
    for (int f = 0; f < 10; f++) begin
      int raw, np, wc, sa, poke;
      raw = $urandom_range(0, 7);
      np  = ref_np(raw);
      wc  = $urandom_range(1, 4);
      sa  = (f % 3 == 0) ? 4094 : $urandom_range(0, 4095);
      llr_q.delete();
      for (int i = 0; i < np * wc; i++) llr_q.push_back(8'($urandom));
      poke = (f % 2 == 0) ? $urandom_range(0, np * wc - 1) : -1;
      build_expect(np, wc, sa);
      run_frame(3'(raw), 13'(wc), 12'(sa), 3, poke, $sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
